// File: rtl/pybit_seq.sv
// pybit_seq: payload bit sequencer for BR/EDR payloads.
// Frames every air-bit strobe into data / CRC / pad periods, builds the FEC 2/3
// block structure (data slots then parity slots) and FEC 1/3 triple-strobe
// slots, and in RX produces a decoder period lagging the payload by one block.
// Optional feature: define PYBIT_SEQ_LENCLIP_EN to clip pylenbit to MAX_LEN.
module pybit_seq #(
  parameter int LENW     = 13,
  parameter int FEC_DATA = 10,
  parameter int FEC_PAR  = 5,
  parameter int CRC_LEN  = 16,
  parameter int MAX_LEN  = 8168
) (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic            py_datvalid_p,
  input  logic            py_st_p,
  input  logic            abort_p,
  input  logic            pk_encode,
  input  logic [LENW-1:0] pylenbit,
  input  logic            crcencode,
  input  logic            fec31encode,
  input  logic            fec32encode,
  output logic            py_period,
  output logic            dec_py_period,
  output logic            daten,
  output logic            fec32en,
  output logic            py_datperiod,
  output logic            py_crc16period,
  output logic            py_daten,
  output logic [LENW-1:0] bitcount,
  output logic            fec32bk_endp,
  output logic            py_endp,
  output logic            dec_py_endp,
  output logic            len_clip
);

  localparam int BLK32 = FEC_DATA + FEC_PAR;
  localparam int SW    = $clog2(BLK32 + 1);

  localparam logic [SW-1:0]   DAT_SLOTS = SW'(FEC_DATA);
  localparam logic [SW-1:0]   DAT_LAST  = SW'(FEC_DATA - 1);
  localparam logic [SW-1:0]   F32_LAST  = SW'(BLK32 - 1);
  localparam logic [LENW:0]   CRC_ADD   = (LENW+1)'(CRC_LEN);
  // One extra bit over the total width so the data limit never wraps.
  localparam logic [LENW+1:0] BLK_DATA  = (LENW+2)'(FEC_DATA);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;

  // Configuration latched at an accepted start.
  logic            fec32_r;
  logic            fec31_r;
  logic            enc_r;
  logic            crc_r;
  logic [LENW-1:0] len_r;
  logic [LENW:0]   total_r;

  // Slot / strobe bookkeeping.
  logic [SW-1:0]   slot_r;
  logic [1:0]      sub_r;
  logic [LENW-1:0] bitcnt_r;
  // Running value of FEC_DATA*k, k being the 1-based block number.
  logic [LENW+1:0] datlim_r;
  logic            dec_r;

  logic [LENW-1:0] len_in_s;
  logic            start_s;
  logic            active_s;
  logic            slot_done_s;
  logic            last_slot_s;
  logic            blk_end_s;
  logic            py_endp_s;
  logic            dec_endp_s;
  logic            py_period_s;
  logic            qual_s;
  logic            datp_s;
  logic            dat_slot_s;

`ifdef PYBIT_SEQ_LENCLIP_EN
  localparam logic [LENW-1:0] MAX_LEN_W = LENW'(MAX_LEN);
  logic clip_in_s;
  logic clip_r;

  assign clip_in_s = (pylenbit > MAX_LEN_W);
  assign len_in_s  = clip_in_s ? MAX_LEN_W : pylenbit;

  // Clip flag: refreshed at every accepted start, held otherwise.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      clip_r <= 1'b0;
    end else if (start_s) begin
      clip_r <= clip_in_s;
    end else begin
      clip_r <= clip_r;
    end
  end

  assign len_clip = clip_r;
`else
  // MAX_LEN is only meaningful when clipping is built in.
  logic unused_cfg_s;
  assign unused_cfg_s = (MAX_LEN > 32'sd0);
  assign len_in_s     = pylenbit;
  assign len_clip     = 1'b0;
`endif

  assign start_s     = (state_r == ST_IDLE) & py_st_p & ~abort_p &
                       (pylenbit != {LENW{1'b0}});
  assign active_s    = (state_r != ST_IDLE);
  assign slot_done_s = py_datvalid_p & active_s & (~fec31_r | (sub_r == 2'd2));
  assign last_slot_s = fec32_r ? (slot_r == F32_LAST) : (slot_r == DAT_LAST);
  // An abort on the final strobe suppresses every end pulse.
  assign blk_end_s   = slot_done_s & last_slot_s & ~abort_p;
  assign py_endp_s   = blk_end_s & (state_r == ST_RUN) &
                       (datlim_r >= {1'b0, total_r});
  assign dec_endp_s  = blk_end_s & (state_r == ST_DRAIN);

  // State register.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides everything, including a start.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_p) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) state_nxt_s = ST_RUN;
          else         state_nxt_s = ST_IDLE;
        end
        ST_RUN: begin
          if (py_endp_s) state_nxt_s = enc_r ? ST_IDLE : ST_DRAIN;
          else           state_nxt_s = ST_RUN;
        end
        ST_DRAIN: begin
          if (dec_endp_s) state_nxt_s = ST_IDLE;
          else            state_nxt_s = ST_DRAIN;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    py_period_s = 1'b0;
    case (state_r)
      ST_RUN:  py_period_s = 1'b1;
      default: py_period_s = 1'b0;
    endcase
  end

  // Configuration latch; FEC 2/3 wins over FEC 1/3 when both are requested.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      fec32_r <= 1'b0;
      fec31_r <= 1'b0;
      enc_r   <= 1'b0;
      crc_r   <= 1'b0;
      len_r   <= {LENW{1'b0}};
      total_r <= {(LENW+1){1'b0}};
    end else if (start_s) begin
      fec32_r <= fec32encode;
      fec31_r <= fec31encode & ~fec32encode;
      enc_r   <= pk_encode;
      crc_r   <= crcencode;
      len_r   <= len_in_s;
      total_r <= {1'b0, len_in_s} + (crcencode ? CRC_ADD : {(LENW+1){1'b0}});
    end else begin
      fec32_r <= fec32_r;
      fec31_r <= fec31_r;
      enc_r   <= enc_r;
      crc_r   <= crc_r;
      len_r   <= len_r;
      total_r <= total_r;
    end
  end

  // Slot, sub-strobe, bit and block counters; cleared whenever we go idle.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      slot_r   <= {SW{1'b0}};
      sub_r    <= 2'd0;
      bitcnt_r <= {LENW{1'b0}};
      datlim_r <= {(LENW+2){1'b0}};
    end else if (state_nxt_s == ST_IDLE) begin
      slot_r   <= {SW{1'b0}};
      sub_r    <= 2'd0;
      bitcnt_r <= {LENW{1'b0}};
      datlim_r <= {(LENW+2){1'b0}};
    end else if (start_s) begin
      slot_r   <= {SW{1'b0}};
      sub_r    <= 2'd0;
      bitcnt_r <= {LENW{1'b0}};
      datlim_r <= BLK_DATA;
    end else if (py_datvalid_p) begin
      if (fec31_r) sub_r <= (sub_r == 2'd2) ? 2'd0 : sub_r + 2'd1;
      else         sub_r <= 2'd0;
      if (slot_done_s) begin
        if (last_slot_s) begin
          slot_r   <= {SW{1'b0}};
          datlim_r <= datlim_r + BLK_DATA;
        end else begin
          slot_r   <= slot_r + {{(SW-1){1'b0}}, 1'b1};
          datlim_r <= datlim_r;
        end
        if (py_period_s & dat_slot_s) bitcnt_r <= bitcnt_r + {{(LENW-1){1'b0}}, 1'b1};
        else                          bitcnt_r <= bitcnt_r;
      end else begin
        slot_r   <= slot_r;
        bitcnt_r <= bitcnt_r;
        datlim_r <= datlim_r;
      end
    end else begin
      slot_r   <= slot_r;
      sub_r    <= sub_r;
      bitcnt_r <= bitcnt_r;
      datlim_r <= datlim_r;
    end
  end

  // Decoder period: opens after the first RX block, closes after the drain block.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      dec_r <= 1'b0;
    end else if (abort_p | dec_endp_s) begin
      dec_r <= 1'b0;
    end else if (blk_end_s & (state_r == ST_RUN) & ~enc_r) begin
      dec_r <= 1'b1;
    end else begin
      dec_r <= dec_r;
    end
  end

  assign dat_slot_s     = (slot_r < DAT_SLOTS);
  assign qual_s         = py_period_s | dec_r;
  assign datp_s         = py_period_s & (bitcnt_r < len_r);

  assign py_period      = py_period_s;
  assign dec_py_period  = dec_r;
  assign daten          = qual_s & dat_slot_s;
  assign fec32en        = qual_s & ~dat_slot_s;
  assign py_datperiod   = datp_s;
  assign py_crc16period = py_period_s & crc_r & (bitcnt_r >= len_r) &
                          ({1'b0, bitcnt_r} < total_r);
  assign py_daten       = datp_s & dat_slot_s;
  assign bitcount       = bitcnt_r;
  assign fec32bk_endp   = blk_end_s;
  assign py_endp        = py_endp_s;
  assign dec_py_endp    = dec_endp_s;

endmodule

// File: tb/tb_pybit_seq.sv
// Testbench for pybit_seq: directed payload runs checked strobe by strobe
// against an arithmetic model of the expected framing.
module tb_pybit_seq;

  localparam int LENW = 13;
  localparam int FD   = 10;
  localparam int FP   = 5;
  localparam int CL   = 16;

  logic            clk_6M = 1'b0;
  logic            rstz = 1'b0;
  logic            py_datvalid_p = 1'b0;
  logic            py_st_p = 1'b0;
  logic            abort_p = 1'b0;
  logic            pk_encode = 1'b0;
  logic [LENW-1:0] pylenbit = '0;
  logic            crcencode = 1'b0;
  logic            fec31encode = 1'b0;
  logic            fec32encode = 1'b0;
  logic            py_period, dec_py_period, daten, fec32en, py_datperiod;
  logic            py_crc16period, py_daten, fec32bk_endp, py_endp, dec_py_endp;
  logic            len_clip;
  logic [LENW-1:0] bitcount;

  int n_chk = 0;
  int n_fail = 0;

  // Expected-value scoreboard.
  logic [22:0] sb_q[$];

  // Model configuration for the payload in flight.
  int m_len, m_total, m_bl, m_nb, m_last, m_abort;
  bit m_crc, m_f32, m_f31, m_rx;

  pybit_seq dut (
    .clk_6M(clk_6M), .rstz(rstz), .py_datvalid_p(py_datvalid_p),
    .py_st_p(py_st_p), .abort_p(abort_p), .pk_encode(pk_encode),
    .pylenbit(pylenbit), .crcencode(crcencode), .fec31encode(fec31encode),
    .fec32encode(fec32encode), .py_period(py_period),
    .dec_py_period(dec_py_period), .daten(daten), .fec32en(fec32en),
    .py_datperiod(py_datperiod), .py_crc16period(py_crc16period),
    .py_daten(py_daten), .bitcount(bitcount), .fec32bk_endp(fec32bk_endp),
    .py_endp(py_endp), .dec_py_endp(dec_py_endp), .len_clip(len_clip)
  );

  // 6 MHz-ish free-running clock.
  always #5 clk_6M = ~clk_6M;

  // Expected outputs just before strobe n (stb=0) or during strobe n (stb=1).
  function automatic logic [22:0] model(input int n, input bit stb);
    int pos, blk, slot, bc;
    bit pp, dp, dat, fe, dpp, cp, pd, bke, pe, de;
    if (n < 1 || n > m_last || (m_abort > 0 && n > m_abort)) return 23'd0;
    pos  = (n - 1) % m_bl;
    blk  = (n - 1) / m_bl;
    slot = m_f31 ? pos / 3 : pos;
    bc   = blk * FD + ((slot < FD) ? slot : FD);
    if (bc > m_nb * FD) bc = m_nb * FD;
    pp   = (n <= m_nb * m_bl);
    dp   = m_rx && (n > m_bl);
    dat  = (slot < FD);
    fe   = !dat;
    dpp  = pp && (bc < m_len);
    cp   = pp && m_crc && (bc >= m_len) && (bc < m_total);
    pd   = dpp && dat;
    bke  = stb && (pos == m_bl - 1) && (n != m_abort);
    pe   = bke && (n == m_nb * m_bl);
    de   = bke && m_rx && (n == (m_nb + 1) * m_bl);
    return {pp, dp, dat, fe, dpp, cp, pd, bke, pe, de, 13'(bc)};
  endfunction

  function automatic logic [22:0] observed();
    return {py_period, dec_py_period, daten, fec32en, py_datperiod,
            py_crc16period, py_daten, fec32bk_endp, py_endp, dec_py_endp, bitcount};
  endfunction

  task automatic compare(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic sb_check(input string tag);
    logic [22:0] exp;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, observed());
    end else begin
      exp = sb_q.pop_front();
      compare(tag, observed(), exp);
    end
  endtask

  // One clock: drive after the edge, push expectation, sample on the falling edge.
  task automatic cyc(input string tag, input bit stb, input bit st, input bit ab,
                     input logic [22:0] exp, input bit scr);
    @(posedge clk_6M);
    #1;
    py_datvalid_p = stb;
    py_st_p       = st;
    abort_p       = ab;
    if (scr) begin
      pylenbit    = ~pylenbit;
      crcencode   = ~crcencode;
      fec32encode = 1'($urandom_range(0, 1));
      fec31encode = 1'($urandom_range(0, 1));
      pk_encode   = ~pk_encode;
    end
    sb_q.push_back(exp);
    @(negedge clk_6M);
    sb_check(tag);
  endtask

  task automatic run_py(input string tag, input int dlen, input int mlen,
                        input bit crc, input bit f32, input bit f31, input bit enc,
                        input bit gap, input int ab_at, input int st_at);
    int lim;
    m_len   = mlen;
    m_crc   = crc;
    m_f32   = f32;
    m_f31   = f31 && !f32;
    m_rx    = !enc;
    m_total = mlen + (crc ? CL : 0);
    m_bl    = m_f32 ? (FD + FP) : (m_f31 ? 3 * FD : FD);
    m_nb    = (m_total + FD - 1) / FD;
    m_last  = m_rx ? (m_nb + 1) * m_bl : m_nb * m_bl;
    m_abort = ab_at;
    pylenbit    = LENW'(dlen);
    crcencode   = crc;
    fec32encode = f32;
    fec31encode = f31;
    pk_encode   = enc;
    cyc({tag, "_start"}, 1'b0, 1'b1, 1'b0, 23'd0, 1'b0);
    lim = (ab_at > 0) ? ab_at + 2 : m_last + 1;
    for (int n = 1; n <= lim; n++) begin
      if (gap) cyc({tag, "_gap"}, 1'b0, 1'b0, 1'b0, model(n, 1'b0), 1'b0);
      cyc($sformatf("%s_s%0d", tag, n), 1'b1, (n == st_at), (n == ab_at),
          model(n, 1'b1), (n == 1));
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk_6M);
    @(negedge clk_6M);
    sb_q.push_back(23'd0);
    sb_check("reset");
    compare("reset_len_clip", {22'd0, len_clip}, 23'd0);
    @(posedge clk_6M);
    #1 rstz = 1'b1;

    // TX, CRC, FEC 2/3: blocks end on 15/30/45/60, py_endp on 60.
    run_py("t1_tx_f32", 20, 20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    // No CRC, no FEC, strobes with gaps: py_endp on 10.
    run_py("t2_plain", 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    // FEC 1/3 with an ignored mid-payload start: py_endp on 30.
    run_py("t3_f31", 8, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 5);
    // RX: decoder period from 16 to 75, drain end on 75.
    run_py("t4_rx", 20, 20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // RX without FEC, gapped strobes.
    run_py("t4b_rx_plain", 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    // Both FEC flags: FEC 2/3 wins, single 15-strobe block.
    run_py("t5_both_fec", 8, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    // Abort at strobe 22 of test 1.
    run_py("t6_abort", 20, 20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 22, 0);

    // Zero-length start is ignored.
    pylenbit = '0;
    cyc("t7_len0_start", 1'b0, 1'b1, 1'b0, 23'd0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("t7_len0_idle", 1'b1, 1'b0, 1'b0, 23'd0, 1'b0);

    // Abort together with start: abort wins.
    pylenbit = 13'd8;
    cyc("t8_abort_start", 1'b0, 1'b1, 1'b1, 23'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("t8_idle", 1'b1, 1'b0, 1'b0, 23'd0, 1'b0);

    // Reset in the middle of a payload.
    m_len = 8; m_crc = 1'b0; m_f32 = 1'b0; m_f31 = 1'b0; m_rx = 1'b0;
    m_total = 8; m_bl = FD; m_nb = 1; m_last = FD; m_abort = 0;
    pylenbit = 13'd8; crcencode = 1'b0; fec32encode = 1'b0;
    fec31encode = 1'b0; pk_encode = 1'b1;
    cyc("t9_start", 1'b0, 1'b1, 1'b0, 23'd0, 1'b0);
    for (int n = 1; n <= 4; n++) cyc("t9_run", 1'b1, 1'b0, 1'b0, model(n, 1'b1), 1'b0);
    @(posedge clk_6M);
    #1 rstz = 1'b0;
    @(posedge clk_6M);
    #1;
    sb_q.push_back(23'd0);
    @(negedge clk_6M);
    sb_check("t9_after_reset");
    rstz = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t9_idle", 1'b1, 1'b0, 1'b0, 23'd0, 1'b0);

    // Oversized length: clipped to 8168 when the feature is built in.
`ifdef PYBIT_SEQ_LENCLIP_EN
    run_py("t10_clip", 8190, 8168, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    compare("t10_len_clip", {22'd0, len_clip}, 23'd1);
`else
    run_py("t10_noclip", 8190, 8190, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    compare("t10_len_clip", {22'd0, len_clip}, 23'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pybit_seq.md
Name: pybit_seq

Overview:
- Parametrised payload bit sequencer; next generation of the payload-bit timing logic.
- Generates per-strobe framing for BR/EDR payloads: data, CRC and pad periods; FEC 2/3 block structure with a generic data/parity split; FEC 1/3 triple-strobe slots.
- In RX, produces a decoder period lagging one FEC block.
- Sits between packet control (start, length, encode flags) and the payload encode/decode datapath.

Parameters:
- LENW, 13, width of length and bit counters.
- FEC_DATA, 10, data slots per FEC block.
- FEC_PAR, 5, parity slots per FEC block (FEC 2/3 only).
- CRC_LEN, 16, CRC bits appended when crcencode=1.
- MAX_LEN, 8168, maximum payload length in bits (used only by the optional feature).

Ports:
- clk_6M  in  1  system clock.
- rstz  in  1  synchronous active-low reset.
- py_datvalid_p  in  1  bit strobe, one clk_6M pulse per air bit.
- py_st_p  in  1  payload start pulse.
- abort_p  in  1  cancel the current payload.
- pk_encode  in  1  1=TX encode, 0=RX decode.
- pylenbit  in  LENW  payload length in bits, excluding CRC.
- crcencode  in  1  append CRC_LEN bits.
- fec31encode  in  1  FEC 1/3 (3 strobes per slot).
- fec32encode  in  1  FEC 2/3 (parity slots per block).
- py_period  out  1  payload encode/receive active.
- dec_py_period  out  1  RX decoder output active.
- daten  out  1  current slot is a data slot.
- fec32en  out  1  current slot is a parity slot.
- py_datperiod  out  1  py_period & bitcount<len.
- py_crc16period  out  1  py_period & len<=bitcount<len+CRC_LEN (crcencode=1 only).
- py_daten  out  1  py_datperiod & daten.
- bitcount  out  LENW  data-slot index since start.
- fec32bk_endp  out  1  last strobe of a block.
- py_endp  out  1  last strobe of payload.
- dec_py_endp  out  1  last strobe of decoder period.
- len_clip  out  1  length was clipped (optional feature).

Behaviour:
- Clock and reset: one clock clk_6M; rstz synchronous, active-low.
- Reset values: all outputs, counters and state are 0; FSM goes to IDLE.
- Effective length: total = pylenbit + (crcencode ? CRC_LEN : 0), computed at LENW+1 bits with no wrap. Latched at py_st_p.
- Flag priority: fec32encode wins if both FEC flags are set.
- Block length in strobes:
  - FEC 2/3: FEC_DATA+FEC_PAR.
  - FEC 1/3: 3*FEC_DATA.
  - Otherwise: FEC_DATA.
- slotcnt counts slots within the block; fec31 sub-counter (0..2) advances slotcnt every 3rd strobe.
- daten = slotcnt<FEC_DATA; fec32en = slotcnt>=FEC_DATA; both are qualified by py_period|dec_py_period.
- bitcount increments on each completed data slot while py_period=1. It reaches total, then counts pad slots; pad slots have py_datperiod=py_crc16period=0.
- fec32bk_endp is a combinational pulse on the final strobe of a block; slotcnt and the sub-counter return to 0 on the same edge.
- Block counter k (starts at 1 at py_st_p, increments on block end).
- py_endp = fec32bk_endp & py_period & (FEC_DATA*k >= total).
- FSM:
  - IDLE: py_st_p with pylenbit!=0 -> RUN; py_period=1 from the next cycle. py_st_p with pylenbit==0 is ignored.
  - RUN: py_endp -> IDLE if pk_encode=1, else -> DRAIN. In RX, dec_py_period sets on the first fec32bk_endp.
  - DRAIN: py_period=0, dec_py_period=1, counters continue for exactly one block. dec_py_endp on that block's final strobe -> IDLE.
- Period clearing: py_period clears on the edge after py_endp; dec_py_period clears after dec_py_endp.
- Interruptions:
  - py_st_p while not IDLE: ignored.
  - abort_p in any state: -> IDLE next edge, all periods clear, no end pulses. abort_p and py_st_p together: abort wins.
  - Input flag changes mid-payload: ignored, since flags are latched at start.

Optional Feature:
- PYBIT_SEQ_LENCLIP_EN defined: pylenbit>MAX_LEN is replaced by MAX_LEN at py_st_p, and len_clip=1 until the next accepted start or reset.
- Undefined: pylenbit is used as-is and len_clip is tied 0.

Test Plan:
- pylenbit=20, crcencode=1, fec32encode=1, pk_encode=1 -> total=36, 4 blocks.
  - fec32bk_endp on strobes 15/30/45/60; py_endp on strobe 60.
  - py_datperiod for data slots 0-19; py_crc16period for slots 20-35; pad slots 36-39.
- pylenbit=8, no CRC, no FEC -> py_endp on strobe 10; fec32en never asserted.
- pylenbit=8, fec31encode=1 -> bitcount advances every 3rd strobe; py_endp on strobe 30.
- Same as test 1 with pk_encode=0 -> dec_py_period rises after strobe 15, py_period falls after strobe 60, dec_py_endp on strobe 75, then IDLE.
- abort_p at strobe 22 of test 1 -> all periods 0 next cycle, no py_endp. py_st_p with pylenbit=0 -> no activity. rstz=0 mid-RUN -> all outputs 0 on the next edge.
- PYBIT_SEQ_LENCLIP_EN set, MAX_LEN=8168, pylenbit=8190 -> len_clip=1 and payload sized as 8168 bits.
